// File: rtl/sprite_compositor_if.sv
// Pixel-stream, offset-handshake and flash signals of the sprite compositor.
// The master drives scan/offset/ROM data; the slave (compositor) returns addresses and pixels.
interface sprite_compositor_if;
  logic [12:0]       pixel_index;
  logic              frame_begin;
  logic signed [7:0] off_x;
  logic signed [6:0] off_y;
  logic              pos_valid;
  logic              pos_ack;
  logic              flash_trig;
  logic [15:0]       bg_colour;
  logic [12:0]       rom_index;
  logic [15:0]       sprite_colour;
  logic [15:0]       oled_data;
  logic              flash_active;

  modport master (
    output pixel_index, frame_begin, off_x, off_y, pos_valid, flash_trig, bg_colour,
           sprite_colour,
    input  pos_ack, rom_index, oled_data, flash_active
  );

  modport slave (
    input  pixel_index, frame_begin, off_x, off_y, pos_valid, flash_trig, bg_colour,
           sprite_colour,
    output pos_ack, rom_index, oled_data, flash_active
  );
endinterface

// File: rtl/sprite_compositor.sv
// Two-stage sprite-over-background compositor for a 96x64 OLED with frame-synchronous offsets.
// Optional hit-flash is enabled by defining SPRITE_FLASH_EN.
module sprite_compositor (
  input logic                 clk,
  input logic                 reset,
  sprite_compositor_if.slave  bus
);

  logic signed [7:0] r_act_x, r_pend_x;
  logic signed [6:0] r_act_y, r_pend_y;
  logic              r_pend_vld;
  logic              r_pos_ack;
  logic [12:0]       r_rom_index;
  logic              r_in_bounds;
  logic [15:0]       r_bg;
  logic [15:0]       r_oled;

  logic [6:0]        w_x, w_y;
  logic signed [8:0] w_dx, w_dy;
  logic              w_in_bounds;
  logic [12:0]       w_rom_index;
  logic              w_flash_white;
  logic [15:0]       w_pixel;

  // Offsets only move at frame_begin; a simultaneous request bypasses the pending slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_act_x    <= '0;
      r_act_y    <= '0;
      r_pend_x   <= '0;
      r_pend_y   <= '0;
      r_pend_vld <= 1'b0;
      r_pos_ack  <= 1'b0;
    end else begin
      r_pos_ack <= bus.pos_valid;
      if (bus.frame_begin) begin
        r_pend_vld <= 1'b0;
        if (bus.pos_valid) begin
          r_act_x <= bus.off_x;
          r_act_y <= bus.off_y;
        end else if (r_pend_vld) begin
          r_act_x <= r_pend_x;
          r_act_y <= r_pend_y;
        end
      end else if (bus.pos_valid) begin
        r_pend_x   <= bus.off_x;
        r_pend_y   <= bus.off_y;
        r_pend_vld <= 1'b1;
      end
    end
  end

  always_comb begin
    w_x  = 7'(bus.pixel_index % 13'd96);
    w_y  = 7'(bus.pixel_index / 13'd96);
    w_dx = $signed({2'b00, w_x}) - $signed({r_act_x[7], r_act_x});
    w_dy = $signed({2'b00, w_y}) - $signed({{2{r_act_y[6]}}, r_act_y});
    w_in_bounds = (bus.pixel_index < 13'd6144) && !w_dx[8] && (w_dx <= 9'sd95) &&
                  !w_dy[8] && (w_dy <= 9'sd63);
    w_rom_index = '0;
    if (w_in_bounds) begin
      w_rom_index = {7'd0, w_dy[5:0]} * 13'd96 + {6'd0, w_dx[6:0]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rom_index <= '0;
      r_in_bounds <= 1'b0;
      r_bg        <= '0;
    end else begin
      r_rom_index <= w_rom_index;
      r_in_bounds <= w_in_bounds;
      r_bg        <= bus.bg_colour;
    end
  end

`ifdef SPRITE_FLASH_EN
  logic [3:0] r_flash_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flash_cnt <= '0;
    end else if (bus.flash_trig) begin
      r_flash_cnt <= 4'd8;
    end else if (bus.frame_begin && (r_flash_cnt != 4'd0)) begin
      r_flash_cnt <= r_flash_cnt - 4'd1;
    end
  end

  assign w_flash_white    = r_flash_cnt[0];
  assign bus.flash_active = (r_flash_cnt != 4'd0);
`else
  assign w_flash_white    = 1'b0;
  assign bus.flash_active = 1'b0;
`endif

  always_comb begin
    w_pixel = r_bg;
    if (r_in_bounds && (bus.sprite_colour != 16'h0000)) begin
      w_pixel = w_flash_white ? 16'hFFFF : bus.sprite_colour;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_oled <= '0;
    end else begin
      r_oled <= w_pixel;
    end
  end

  assign bus.pos_ack   = r_pos_ack;
  assign bus.rom_index = r_rom_index;
  assign bus.oled_data = r_oled;

endmodule
